sram_req_ctrl: RTL and testbench

Initiator-side controller that turns a valid/ready word request channel into cycle-accurate accesses on the 16K×32 single-port SRAM macro interface (CEB/WEB/A/D/BWEB in, latched Q out). It issues one access per cycle, tracks the one-cycle macro read latency, and buffers read data in a small response FIFO so the consumer can stall without losing data. It also puts the macro into light sleep (SLP) after a programmable idle period and wakes it on demand. It sits between the CPU/DMA request logic and the SRAM macro instance.

---
 rtl/sram_req_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_req_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a 16Kx32 single-port SRAM macro with
// one-cycle read capture, in-order response FIFO and idle light-sleep control.
module sram_req_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned SLEEP_IDLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        CEB,
  output logic        WEB,
  output logic [13:0] A,
  output logic [31:0] D,
  output logic [31:0] BWEB,
  input  logic [31:0] Q,
  output logic        SLP
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = (SLEEP_IDLE > 2) ? $clog2(SLEEP_IDLE) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((SLEEP_IDLE == 0) ? 0 : SLEEP_IDLE - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_SLEEP,
    ST_WAKE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            inflight_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            idle;
  logic            push;
  logic            pop;
  logic            has_credit;
  logic [CW:0]     used;

  assign accept = req_valid && req_ready;
  assign idle   = !req_valid && !inflight_q && (count_q == '0);
  assign push   = inflight_q;
  assign pop    = rsp_valid && rsp_ready;

  // Credits cover both stored entries and the read whose data is still on Q,
  // so a capture can never land on a full FIFO.
  assign used       = {1'b0, count_q} + (CW + 1)'(inflight_q);
  assign has_credit = used < (CW + 1)'(DEPTH);

  // ---------------- sleep FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // ---------------- sleep FSM: next state ----------------
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if ((SLEEP_IDLE != 0) && (idle_cnt_q == IDLE_LAST)) begin
          state_d    = ST_SLEEP;
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LAST) begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      ST_SLEEP: begin
        if (req_valid) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d    = ST_ACTIVE;
        idle_cnt_d = '0;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // ---------------- sleep FSM: outputs ----------------
  // rst gates req_ready so the handshake and macro pins drop asynchronously.
  always_comb begin
    SLP       = (state_q == ST_SLEEP);
    req_ready = !rst && (state_q == ST_ACTIVE) && has_credit;
  end

  // ---------------- macro pins ----------------
  always_comb begin
    CEB  = 1'b1;
    WEB  = 1'b1;
    A    = '0;
    D    = '0;
    BWEB = '1;
    if (accept) begin
      CEB = 1'b0;
      A   = req_addr;
      if (req_write) begin
        WEB = 1'b0;
        D   = req_wdata;
        for (int unsigned b = 0; b < 32; b++) begin
          BWEB[b] = ~req_wstrb[b / 8];
        end
      end
    end
  end

  // ---------------- read tracking and response FIFO ----------------
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= accept && !req_write;
      count_q    <= count_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= Q;
  end

  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = rsp_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Randomized bench for sram_req_ctrl: drives requests against a behavioural
// SRAM macro and compares every cycle with a transaction-level reference model.
module tb_sram_req_ctrl;

  localparam int unsigned DEPTH      = 3;
  localparam int unsigned SLEEP_IDLE = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        CEB, WEB, SLP;
  logic [13:0] A;
  logic [31:0] D, BWEB;
  bit   [31:0] Q;

  sram_req_ctrl #(.DEPTH(DEPTH), .SLEEP_IDLE(SLEEP_IDLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB), .Q(Q), .SLP(SLP)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro: bit-masked write, Q updated only on reads.
  bit [31:0] sram [16384];
  always @(posedge clk) begin
    if (!CEB) begin
      if (!WEB) sram[A] <= (sram[A] & BWEB) | (D & ~BWEB);
      else      Q <= sram[A];
    end
  end

  // Reference model state
  typedef struct {
    logic [31:0] data;
    int unsigned avail;
  } rsp_t;

  bit [31:0]   refmem [16384];
  rsp_t        exp_q [$];
  int unsigned cyc;
  int unsigned idle_run;
  bit          asleep, waking;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=0x%08h exp=0x%08h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    idle_run = 0;
    asleep   = 1'b0;
    waking   = 1'b0;
  endtask

  task automatic step(input logic v, input logic w, input logic [13:0] a,
                      input logic [31:0] wd, input logic [3:0] ws, input logic rr);
    logic        e_ready, e_rv, acc, e_idle;
    logic [31:0] e_rd, e_bweb, merged;
    rsp_t        r;
    @(negedge clk);
    req_valid = v; req_write = w; req_addr = a;
    req_wdata = wd; req_wstrb = ws; rsp_ready = rr;
    #1;
    e_ready = !asleep && !waking && (exp_q.size() < DEPTH);
    e_rv    = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
    e_rd    = e_rv ? exp_q[0].data : 32'h0;
    acc     = v && e_ready;
    e_bweb  = 32'hFFFF_FFFF;
    if (acc && w) begin
      for (int i = 0; i < 4; i++) e_bweb[i*8 +: 8] = ws[i] ? 8'h00 : 8'hFF;
    end
    check_eq("req_ready", req_ready, e_ready);
    check_eq("rsp_valid", rsp_valid, e_rv);
    check_eq("rsp_rdata", rsp_rdata, e_rd);
    check_eq("SLP",  SLP, asleep);
    check_eq("CEB",  CEB, !acc);
    check_eq("WEB",  WEB, !(acc && w));
    check_eq("A",    A, acc ? a : 14'h0);
    check_eq("D",    D, (acc && w) ? wd : 32'h0);
    check_eq("BWEB", BWEB, e_bweb);

    e_idle = !v && (exp_q.size() == 0);
    if (e_rv && rr) void'(exp_q.pop_front());
    if (acc) begin
      if (w) begin
        merged = refmem[a];
        for (int i = 0; i < 4; i++) if (ws[i]) merged[i*8 +: 8] = wd[i*8 +: 8];
        refmem[a] = merged;
      end else begin
        r.data  = refmem[a];
        r.avail = cyc + 2;
        exp_q.push_back(r);
      end
    end
    if (waking) begin
      waking   = 1'b0;
      idle_run = 0;
    end else if (asleep) begin
      if (v) begin
        asleep = 1'b0;
        waking = 1'b1;
      end
    end else if (e_idle) begin
      idle_run++;
      if (SLEEP_IDLE != 0 && idle_run == SLEEP_IDLE) begin
        asleep   = 1'b1;
        idle_run = 0;
      end
    end else begin
      idle_run = 0;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 14'h0, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", req_ready, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_CEB", CEB, 1'b1);
    check_eq("rst_WEB", WEB, 1'b1);
    check_eq("rst_A", A, 14'h0);
    check_eq("rst_D", D, 32'h0);
    check_eq("rst_BWEB", BWEB, 32'hFFFF_FFFF);
    check_eq("rst_SLP", SLP, 1'b0);
  endtask

  initial begin
    logic [13:0] ra;
    cyc = 0;
    model_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h5;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b1;
    #3;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Full write then read-back
    step(1'b1, 1'b1, 14'h0005, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step(1'b1, 1'b0, 14'h0005, 32'h0, 4'h0, 1'b1);
    idle_steps(3);

    // Partial byte-strobe write merge
    step(1'b1, 1'b1, 14'h0010, 32'h1122_3344, 4'hF, 1'b1);
    step(1'b1, 1'b1, 14'h0010, 32'hAABB_CCDD, 4'b0101, 1'b1);
    step(1'b1, 1'b0, 14'h0010, 32'h0, 4'h0, 1'b1);
    idle_steps(3);

    // Back-to-back streaming reads
    for (int unsigned i = 0; i < 16; i++) step(1'b1, 1'b0, 14'(16'h100 + i), 32'h0, 4'h0, 1'b1);
    idle_steps(3);

    // Backpressure: credits run out, then drain and resume
    for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b0, 14'(16'h100 + i), 32'h0, 4'h0, 1'b0);
    for (int unsigned i = 0; i < 6; i++) step(1'b1, 1'b0, 14'(16'h108 + i), 32'h0, 4'h0, 1'b1);
    idle_steps(3);

    // Sleep entry and wake-up
    idle_steps(20);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 14'h0005, 32'h0, 4'h0, 1'b1);
    idle_steps(3);

    // Random traffic with periodic idle bursts long enough to sleep
    for (int unsigned i = 0; i < 2000; i++) begin
      if (i % 300 == 299) begin
        idle_steps(SLEEP_IDLE + 4);
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'($urandom_range(0, 31));
        step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra, $urandom,
             4'($urandom), $urandom_range(0, 9) < 7);
      end
    end
    idle_steps(4);

    // Asynchronous reset with reads pending
    step(1'b1, 1'b0, 14'h0005, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 14'h0010, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h0011; rsp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    idle_steps(4);
    step(1'b1, 1'b0, 14'h0005, 32'h0, 4'h0, 1'b1);
    idle_steps(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
